// File: rtl/obf_serial_adder_lock.sv
// Key-locked multi-channel bit-serial adder: outputs are LFSR-corrupted until the key sequence is seen.
// Define OBF_BLACKHOLE_EN to compile in the BLACKHOLE state that permanently locks after MAX_TRIES failures.
module obf_serial_adder_lock #(
    parameter int                         NCH       = 1,
    parameter int                         WORD_LEN  = 4,
    parameter int                         KEY_LEN   = 3,
    parameter logic [2*NCH*KEY_LEN-1:0]   KEY       = 6'b11_01_10,
    parameter int                         MAX_TRIES = 2,
    parameter logic [7:0]                 LFSR_SEED = 8'hA5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [NCH-1:0] line1,
    input  logic [NCH-1:0] line2,
    output logic [NCH-1:0] outp,
    output logic [NCH-1:0] overflw,
    output logic           unlocked
);

    localparam int IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int BIT_W = $clog2(WORD_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_LEN - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_LEN - 1);

    // The corruption mask is taken from the low LFSR bits, so at most 8 channels.
    if (WORD_LEN < 2 || KEY_LEN < 1 || MAX_TRIES < 1 || NCH < 1 || NCH > 8 || LFSR_SEED == 8'h00)
    begin : g_param_err
        $error("obf_serial_adder_lock: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_LOCKED,
        S_UNLOCKED
`ifdef OBF_BLACKHOLE_EN
        , S_BLACKHOLE
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [NCH-1:0]   carry_q, carry_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [NCH-1:0]   outp_q, outp_d;
    logic [NCH-1:0]   ovf_q, ovf_d;
`ifdef OBF_BLACKHOLE_EN
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);
    logic [FAIL_W-1:0] fail_q, fail_d;
`endif

    logic [7:0]       lfsr_step;
    logic [2*NCH-1:0] key_word;
    logic [NCH-1:0]   sum_bits;
    logic [NCH-1:0]   carry_nxt;

    always_comb begin
        lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        key_word  = KEY[int'(idx_q)*2*NCH +: 2*NCH];
        sum_bits  = line1 ^ line2 ^ carry_q;
        carry_nxt = (line1 & line2) | (line1 & carry_q) | (line2 & carry_q);

        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        carry_d = carry_q;
        lfsr_d  = lfsr_q;
        outp_d  = line1 ^ line2 ^ lfsr_q[NCH-1:0];
        ovf_d   = '0;
`ifdef OBF_BLACKHOLE_EN
        fail_d  = fail_q;
`endif

        case (state_q)
            S_LOCKED: begin
                lfsr_d = lfsr_step;
`ifdef OBF_BLACKHOLE_EN
                if (fail_q >= FAIL_MAX) state_d = S_BLACKHOLE;
                else
`endif
                if ({line2, line1} == key_word) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_UNLOCKED;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    // Restart from the first key word; a partial match is never reused.
                    idx_d = '0;
`ifdef OBF_BLACKHOLE_EN
                    if (fail_q != FAIL_MAX) fail_d = fail_q + 1'b1;
`endif
                end
            end
            S_UNLOCKED: begin
                outp_d = sum_bits;
                if (bit_q == BIT_LAST) begin
                    ovf_d   = carry_nxt;
                    carry_d = '0;
                    bit_d   = '0;
                end else begin
                    carry_d = carry_nxt;
                    bit_d   = bit_q + 1'b1;
                end
            end
`ifdef OBF_BLACKHOLE_EN
            S_BLACKHOLE: lfsr_d = lfsr_step;
`endif
            default: state_d = S_LOCKED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_LOCKED;
            idx_q   <= '0;
            bit_q   <= '0;
            carry_q <= '0;
            lfsr_q  <= LFSR_SEED;
            outp_q  <= '0;
            ovf_q   <= '0;
`ifdef OBF_BLACKHOLE_EN
            fail_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            carry_q <= carry_d;
            lfsr_q  <= lfsr_d;
            outp_q  <= outp_d;
            ovf_q   <= ovf_d;
`ifdef OBF_BLACKHOLE_EN
            fail_q  <= fail_d;
`endif
        end
    end

    assign outp     = outp_q;
    assign overflw  = ovf_q;
    assign unlocked = (state_q == S_UNLOCKED);

endmodule

// File: tb/tb_obf_serial_adder_lock.sv
// Directed + randomized bench for obf_serial_adder_lock against a word-level arithmetic reference model.
module tb_obf_serial_adder_lock;

    localparam int NCH = 1;
    localparam int WL  = 4;
    localparam int KL  = 3;
    localparam int MT  = 2;
`ifdef OBF_BLACKHOLE_EN
    localparam bit BH = 1'b1;
`else
    localparam bit BH = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [NCH-1:0] line1 = '0;
    logic [NCH-1:0] line2 = '0;
    logic [NCH-1:0] outp;
    logic [NCH-1:0] overflw;
    logic unlocked;

    int checks   = 0;
    int failures = 0;

    // Reference model state: 0 locked, 1 unlocked, 2 blackhole
    int         m_state = 0;
    int         m_idx   = 0;
    int         m_fail  = 0;
    logic [7:0] m_lfsr  = 8'hA5;
    int         m_bit   = 0;
    int         m_a     = 0;
    int         m_b     = 0;
    logic       m_outp  = 1'b0;
    logic       m_ovf   = 1'b0;
    logic [5:0] key     = 6'b11_01_10;

    always #5 clock = ~clock;

    obf_serial_adder_lock #(
        .NCH(NCH), .WORD_LEN(WL), .KEY_LEN(KL), .KEY(6'b11_01_10),
        .MAX_TRIES(MT), .LFSR_SEED(8'hA5)
    ) dut (
        .clock(clock), .reset(reset), .line1(line1), .line2(line2),
        .outp(outp), .overflw(overflw), .unlocked(unlocked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic a, input logic b);
        int s;
        if (!r) begin
            m_state = 0; m_idx = 0; m_fail = 0; m_lfsr = 8'hA5;
            m_bit = 0; m_a = 0; m_b = 0; m_outp = 1'b0; m_ovf = 1'b0;
        end else if (m_state == 1) begin
            m_a += int'(a) << m_bit;
            m_b += int'(b) << m_bit;
            s = m_a + m_b;
            m_outp = s[m_bit];
            if (m_bit == WL - 1) begin
                m_ovf = s[WL];
                m_a = 0; m_b = 0; m_bit = 0;
            end else begin
                m_ovf = 1'b0;
                m_bit++;
            end
        end else begin
            m_outp = a ^ b ^ m_lfsr[0];
            m_ovf  = 1'b0;
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            if (m_state == 0) begin
                if (BH && m_fail >= MT) m_state = 2;
                else if ({b, a} == 2'((key >> (2 * m_idx)) & 6'b11)) begin
                    if (m_idx == KL - 1) begin m_state = 1; m_idx = 0; end
                    else m_idx++;
                end else begin
                    m_idx = 0;
                    if (m_fail < MT) m_fail++;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic a, input logic b, input string tag);
        reset = r; line1 = a; line2 = b;
        @(posedge clock);
        model(r, a, b);
        #1;
        chk({tag, "/outp"}, 32'(outp), 32'(m_outp));
        chk({tag, "/overflw"}, 32'(overflw), 32'(m_ovf));
        chk({tag, "/unlocked"}, 32'(unlocked), 32'(m_state == 1));
    endtask

    // Key words given as {line2,line1}
    task automatic word(input logic [1:0] w, input string tag);
        step(1'b1, w[0], w[1], tag);
    endtask

    initial begin
        logic [3:0] va, vb, eo, ev;

        // Reset held for ten cycles
        repeat (10) step(1'b0, 1'($urandom), 1'($urandom), "reset_hold");
        chk("reset_outp", 32'(outp), 0);
        chk("reset_overflw", 32'(overflw), 0);
        chk("reset_unlocked", 32'(unlocked), 0);

        // Locked: LFSR corruption on random traffic
        repeat (24) step(1'b1, 1'($urandom), 1'($urandom), "lock_rand");
        step(1'b0, 1'b0, 1'b0, "reset_a");

        // Correct key
        word(2'b10, "key0");
        word(2'b01, "key1");
        chk("pre_unlock", 32'(unlocked), 0);
        word(2'b11, "key2");
        chk("unlock_after_key", 32'(unlocked), 1);

        // 11 + 6 = 17
        va = 4'b1011; vb = 4'b0110; eo = 4'b0001; ev = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, va[i], vb[i], "add_11_6");
            chk($sformatf("add_11_6_outp%0d", i), 32'(outp), 32'(eo[i]));
            chk($sformatf("add_11_6_ovf%0d", i), 32'(overflw), 32'(ev[i]));
        end
        repeat (40) step(1'b1, 1'($urandom), 1'($urandom), "add_rand");

        // Reset mid-word forces relock and clears carry
        step(1'b1, 1'b1, 1'b1, "midword0");
        step(1'b1, 1'b1, 1'b0, "midword1");
        step(1'b0, 1'b1, 1'b1, "midword_rst");
        chk("midrst_unlocked", 32'(unlocked), 0);
        word(2'b11, "relock_bad");
        chk("relock_still_locked", 32'(unlocked), 0);
        word(2'b10, "rekey0");
        word(2'b01, "rekey1");
        word(2'b11, "rekey2");
        chk("rekey_unlocked", 32'(unlocked), 1);
        step(1'b1, 1'b1, 1'b1, "carry_clear");
        chk("carry_clear_outp", 32'(outp), 0);
        step(1'b1, 1'b0, 1'b0, "carry_prop");
        chk("carry_prop_outp", 32'(outp), 1);

        // Mismatch mid-key restarts the index
        step(1'b0, 1'b0, 1'b0, "reset_b");
        word(2'b10, "restart0");
        word(2'b00, "restart1");
        word(2'b10, "restart2");
        word(2'b01, "restart3");
        chk("restart_not_yet", 32'(unlocked), 0);
        word(2'b11, "restart4");
        chk("restart_unlocked", 32'(unlocked), 1);

        // Two failures then the correct key
        step(1'b0, 1'b0, 1'b0, "reset_c");
        word(2'b00, "bh0");
        word(2'b00, "bh1");
        word(2'b10, "bh2");
        word(2'b01, "bh3");
        word(2'b11, "bh4");
        chk("blackhole_unlocked", 32'(unlocked), BH ? 0 : 1);
        repeat (8) step(1'b1, 1'($urandom), 1'($urandom), "after_bh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
